// File: rtl/hbif_uart_bridge_if.sv
// ============================================================================
// hbif_uart_bridge_if : register-bus handshake between UART bridge and target
// Rev 1.0
// ============================================================================
`default_nettype none

interface hbif_uart_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              reg_req_o;
  logic              reg_we_o;
  logic [ADDR_W-1:0] reg_addr_o;
  logic [DATA_W-1:0] reg_wdata_o;
  logic [DATA_W-1:0] reg_rdata_i;
  logic              reg_ack_i;

  modport master (
    output reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o,
    input  reg_rdata_i, reg_ack_i
  );

  modport slave (
    input  reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o,
    output reg_rdata_i, reg_ack_i
  );
endinterface

`default_nettype wire

// File: rtl/hbif_uart_bridge.sv
// ============================================================================
// hbif_uart_bridge : 8N1 UART command frames -> single register-bus transfers
// Optional inter-byte timeout enabled by macro HBIF_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module hbif_uart_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               uart_rx_i,
  output logic               uart_tx_o,
  output logic               busy_o,
  hbif_uart_bridge_if.master bus
);

  localparam int DATA_BYTES = DATA_W / 8;
  localparam int CW         = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]    C_CMD_W     = 8'h57;
  localparam logic [7:0]    C_CMD_R     = 8'h52;
  localparam logic [7:0]    C_ACK       = 8'h4B;
  localparam logic [7:0]    C_NAK       = 8'h4E;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] F_IDLE  = 3'd0;
  localparam logic [2:0] F_ADDR  = 3'd1;
  localparam logic [2:0] F_WDATA = 3'd2;
  localparam logic [2:0] F_BUS   = 3'd3;
  localparam logic [2:0] F_RESP  = 3'd4;

  generate
    if (CLKS_PER_BIT < 4 || ADDR_W < 1 || ADDR_W > 8 || DATA_W < 8 || DATA_W > 32 ||
        (DATA_W % 8) != 0 || TIMEOUT_BITS < 1) begin : g_bad_params
      $error("hbif_uart_bridge: parameter out of range");
    end
  endgenerate

  logic              r_rx_meta, r_rx_sync, r_rx_prev;
  logic [1:0]        r_rx_state;
  logic [CW-1:0]     r_rx_cnt;
  logic [2:0]        r_rx_bitn;
  logic [7:0]        r_rx_shift;
  logic              r_rx_valid, r_rx_ferr;

  logic [2:0]        r_fsm;
  logic [2:0]        r_bcnt;
  logic              r_req, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              r_tx_busy, r_tx_line;
  logic [CW-1:0]     r_tx_cnt;
  logic [3:0]        r_tx_bitn;
  logic [7:0]        r_tx_data;
  logic [DATA_W-1:0] r_rsp_buf;
  logic [2:0]        r_rsp_left;

  logic              w_bus_ack, w_bad_cmd, w_timeout, w_ev_valid;
  logic [DATA_W-1:0] w_ev_buf;
  logic [2:0]        w_ev_n;
  logic              w_tx_done, w_tx_free;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx_i;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bitn  <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      if (!en_i) begin
        r_rx_state <= RX_IDLE;
      end else begin
        case (r_rx_state)
          RX_IDLE: begin
            if (r_rx_prev && !r_rx_sync) begin
              r_rx_state <= RX_START;
              r_rx_cnt   <= '0;
            end
          end
          RX_START: begin
            if (r_rx_cnt == C_HALF_LAST) begin
              r_rx_cnt   <= '0;
              r_rx_bitn  <= '0;
              r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
          RX_DATA: begin
            if (r_rx_cnt == C_BIT_LAST) begin
              r_rx_cnt   <= '0;
              r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
              r_rx_bitn  <= r_rx_bitn + 1'b1;
              if (r_rx_bitn == 3'd7) r_rx_state <= RX_STOP;
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
          default: begin
            if (r_rx_cnt == C_BIT_LAST) begin
              r_rx_valid <= r_rx_sync;
              r_rx_ferr  <= !r_rx_sync;
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef HBIF_TIMEOUT_EN
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TOW       = $clog2(TO_CYCLES + 1);

  logic [TOW-1:0] r_to_cnt;
  logic           w_to_armed;

  assign w_to_armed = en_i && (r_fsm == F_ADDR || r_fsm == F_WDATA);
  assign w_timeout  = w_to_armed && !r_rx_valid && (r_to_cnt == TOW'(TO_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to_cnt <= '0;
    end else if (!w_to_armed || r_rx_valid) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_bus_ack  = en_i && (r_fsm == F_BUS) && r_req && bus.reg_ack_i;
  assign w_bad_cmd  = en_i && (r_fsm == F_IDLE) && r_rx_valid &&
                      (r_rx_shift != C_CMD_W) && (r_rx_shift != C_CMD_R);
  assign w_ev_valid = w_bus_ack || w_bad_cmd || w_timeout;

  // Response bytes are MSB-aligned so the first byte on the wire is always the top byte
  always_comb begin
    w_ev_buf = DATA_W'(C_NAK) << (DATA_W - 8);
    w_ev_n   = 3'd1;
    if (w_bus_ack) begin
      if (r_we) begin
        w_ev_buf = DATA_W'(C_ACK) << (DATA_W - 8);
      end else begin
        w_ev_buf = bus.reg_rdata_i;
        w_ev_n   = 3'(DATA_BYTES);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm   <= F_IDLE;
      r_bcnt  <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (!en_i) begin
      r_fsm <= F_IDLE;
      r_req <= 1'b0;
    end else begin
      case (r_fsm)
        F_IDLE: begin
          if (r_rx_valid && (r_rx_shift == C_CMD_W || r_rx_shift == C_CMD_R)) begin
            r_we  <= (r_rx_shift == C_CMD_W);
            r_fsm <= F_ADDR;
          end
        end
        F_ADDR: begin
          if (r_rx_ferr || w_timeout) begin
            r_fsm <= F_IDLE;
          end else if (r_rx_valid) begin
            r_addr <= r_rx_shift[ADDR_W-1:0];
            r_bcnt <= '0;
            if (r_we) begin
              r_fsm <= F_WDATA;
            end else begin
              r_fsm <= F_BUS;
              r_req <= 1'b1;
            end
          end
        end
        F_WDATA: begin
          if (r_rx_ferr || w_timeout) begin
            r_fsm <= F_IDLE;
          end else if (r_rx_valid) begin
            r_wdata <= (r_wdata << 8) | DATA_W'(r_rx_shift);
            r_bcnt  <= r_bcnt + 1'b1;
            if (r_bcnt == 3'(DATA_BYTES - 1)) begin
              r_fsm <= F_BUS;
              r_req <= 1'b1;
            end
          end
        end
        F_BUS: begin
          if (w_bus_ack) begin
            r_req <= 1'b0;
            r_fsm <= F_RESP;
          end
        end
        default: begin
          if (r_rsp_left == '0 && !r_tx_busy) r_fsm <= F_IDLE;
        end
      endcase
    end
  end

  assign w_tx_done = r_tx_busy && (r_tx_cnt == C_BIT_LAST) && (r_tx_bitn == 4'd9);
  assign w_tx_free = !r_tx_busy || w_tx_done;

  // A new response starts straight from the event so the start bit leaves one cycle after it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_busy  <= 1'b0;
      r_tx_line  <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_bitn  <= '0;
      r_tx_data  <= '0;
      r_rsp_buf  <= '0;
      r_rsp_left <= '0;
    end else if (w_tx_free && w_ev_valid) begin
      r_tx_busy  <= 1'b1;
      r_tx_line  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bitn  <= '0;
      r_tx_data  <= w_ev_buf[DATA_W-1 -: 8];
      r_rsp_buf  <= w_ev_buf << 8;
      r_rsp_left <= w_ev_n - 1'b1;
    end else if (w_tx_free && en_i && r_rsp_left != '0) begin
      r_tx_busy  <= 1'b1;
      r_tx_line  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bitn  <= '0;
      r_tx_data  <= r_rsp_buf[DATA_W-1 -: 8];
      r_rsp_buf  <= r_rsp_buf << 8;
      r_rsp_left <= r_rsp_left - 1'b1;
    end else begin
      if (w_ev_valid) begin
        r_rsp_buf  <= w_ev_buf;
        r_rsp_left <= w_ev_n;
      end else if (!en_i) begin
        r_rsp_left <= '0;
      end
      if (w_tx_done) begin
        r_tx_busy <= 1'b0;
        r_tx_line <= 1'b1;
      end else if (r_tx_busy) begin
        if (r_tx_cnt == C_BIT_LAST) begin
          r_tx_cnt  <= '0;
          r_tx_bitn <= r_tx_bitn + 1'b1;
          r_tx_line <= (r_tx_bitn == 4'd8) ? 1'b1 : r_tx_data[r_tx_bitn[2:0]];
        end else begin
          r_tx_cnt <= r_tx_cnt + 1'b1;
        end
      end
    end
  end

  assign uart_tx_o       = r_tx_line;
  assign busy_o          = (r_fsm != F_IDLE);
  assign bus.reg_req_o   = r_req;
  assign bus.reg_we_o    = r_we;
  assign bus.reg_addr_o  = r_addr;
  assign bus.reg_wdata_o = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_hbif_uart_bridge.sv
// ============================================================================
// tb_hbif_uart_bridge : randomized and directed frames against a frame-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hbif_uart_bridge;
  localparam int CPB = 4;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int DB  = DW / 8;
  localparam int TOB = 16;

  logic clk = 1'b0;
  logic rst_n, en, rx, tx, busy;
  logic ack_resp = 1'b0, ack_spur = 1'b0;
  logic [DW-1:0] rdata_drv = '0, rdata_val = '0;

  hbif_uart_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();
  assign bif.reg_ack_i   = ack_resp | ack_spur;
  assign bif.reg_rdata_i = rdata_drv;

  hbif_uart_bridge #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_BITS(TOB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .uart_rx_i(rx),
    .uart_tx_o(tx), .busy_o(busy), .bus(bif)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  bit resp_en = 1'b1;
  int txn_n = 0, ack_cyc = 0, tx_bad = 0;
  logic obs_we;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wd;
  bit stable, req_drop;
  logic [7:0] tx_q[$];
  int start_q[$];

  logic [7:0] frame[$];
  bit exp_bus, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd;
  logic [7:0] exp_tx[$];

  // Bus target: random ack delay, records the request and whether it stayed stable
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (resp_en && bif.reg_req_o === 1'b1) begin
        txn_n++;
        obs_we = bif.reg_we_o; obs_addr = bif.reg_addr_o; obs_wd = bif.reg_wdata_o;
        stable = 1'b1;
        d = $urandom_range(0, 5);
        repeat (d) begin
          @(negedge clk);
          if (bif.reg_req_o !== 1'b1 || bif.reg_we_o !== obs_we ||
              bif.reg_addr_o !== obs_addr || bif.reg_wdata_o !== obs_wd) stable = 1'b0;
        end
        rdata_drv = rdata_val; ack_resp = 1'b1; ack_cyc = cyc;
        @(negedge clk);
        ack_resp = 1'b0; rdata_drv = DW'($urandom);
        req_drop = (bif.reg_req_o === 1'b0);
      end
    end
  end

  // UART line monitor
  initial begin
    logic [7:0] b;
    int st;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        st = cyc;
        repeat (CPB / 2) @(negedge clk);
        if (tx !== 1'b0) tx_bad++;
        else begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
          end
          repeat (CPB) @(negedge clk);
          if (tx !== 1'b1) tx_bad++;
          tx_q.push_back(b);
          start_q.push_back(st);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopb);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopb;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame(input int from);
    for (int i = from; i < frame.size(); i++) send_byte(frame[i], 1'b1);
  endtask

  task automatic clear_obs();
    tx_q.delete(); start_q.delete();
    txn_n = 0; tx_bad = 0;
  endtask

  // Frame-level reference: what the bridge should do for the bytes in frame[]
  task automatic model(input logic [DW-1:0] rd);
    int need;
    exp_tx.delete();
    exp_bus = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
    if (frame[0] == 8'h57 || frame[0] == 8'h52) begin
      need = (frame[0] == 8'h57) ? 2 + DB : 2;
      if (frame.size() < need) begin
`ifdef HBIF_TIMEOUT_EN
        exp_tx.push_back(8'h4E);
`endif
      end else begin
        exp_bus = 1'b1;
        exp_we  = (frame[0] == 8'h57);
        exp_addr = frame[1][AW-1:0];
        if (exp_we) begin
          for (int i = 0; i < DB; i++) exp_wd = (exp_wd << 8) | DW'(frame[2 + i]);
          exp_tx.push_back(8'h4B);
        end else begin
          for (int i = 0; i < DB; i++) exp_tx.push_back(8'(rd >> (8 * (DB - 1 - i))));
        end
      end
    end else begin
      exp_tx.push_back(8'h4E);
    end
  endtask

  task automatic run_check(input string tag);
    int k = 0;
    model(rdata_val);
    while (tx_q.size() < exp_tx.size() && k < 800) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_tx_wait"}, 32'(k < 800), 32'd1);
    repeat (12) @(negedge clk);
    chk({tag, "_txn_count"}, 32'(txn_n), 32'(exp_bus));
    if (exp_bus) begin
      chk({tag, "_we"}, 32'(obs_we), 32'(exp_we));
      chk({tag, "_addr"}, 32'(obs_addr), 32'(exp_addr));
      if (exp_we) chk({tag, "_wdata"}, 32'(obs_wd), 32'(exp_wd));
      chk({tag, "_req_stable"}, 32'(stable), 32'd1);
      chk({tag, "_req_drop"}, 32'(req_drop), 32'd1);
      if (start_q.size() > 0) chk({tag, "_tx_latency"}, 32'(start_q[0] - ack_cyc), 32'd1);
    end
    chk({tag, "_tx_count"}, 32'(tx_q.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      chk({tag, "_tx_byte"}, 32'(tx_q[i]), 32'(exp_tx[i]));
    if (start_q.size() > 1) chk({tag, "_tx_gap"}, 32'(start_q[1] - start_q[0]), 32'(10 * CPB));
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_tx_framing"}, 32'(tx_bad), 32'd0);
  endtask

  initial begin
    int k;
    logic [7:0] c;
    rst_n = 1'b0; en = 1'b1; rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_req", 32'(bif.reg_req_o), 32'd0);
    chk("rst_we", 32'(bif.reg_we_o), 32'd0);
    chk("rst_addr", 32'(bif.reg_addr_o), 32'd0);
    chk("rst_wdata", 32'(bif.reg_wdata_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    clear_obs(); frame = '{8'h57, 8'h12, 8'hBE, 8'hEF};
    send_frame(0); run_check("write");

    clear_obs(); frame = '{8'h52, 8'h34}; rdata_val = 16'hCAFE;
    send_frame(0); run_check("read");

    clear_obs(); frame = '{8'h41};
    send_frame(0);
    ack_spur = 1'b1; @(negedge clk); ack_spur = 1'b0;
    run_check("badcmd");

    clear_obs(); frame = '{8'h52, 8'h01}; rdata_val = 16'h0005;
    send_byte(8'h57, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    send_frame(0); run_check("ferr");

    for (int n = 0; n < 10; n++) begin
      clear_obs();
      rdata_val = DW'($urandom);
      case ($urandom_range(0, 2))
        0: frame = '{8'h57, 8'($urandom), 8'($urandom), 8'($urandom)};
        1: frame = '{8'h52, 8'($urandom)};
        default: begin
          c = 8'($urandom);
          while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
          frame = '{c};
        end
      endcase
      send_frame(0); run_check("random");
    end

    clear_obs();
    send_byte(8'h57, 1'b1); send_byte(8'h10, 1'b1);
    @(negedge clk); en = 1'b0;
    repeat (6) @(negedge clk);
    chk("en_busy_low", 32'(busy), 32'd0);
    en = 1'b1;
    frame = '{8'h57, 8'h22, 8'hAA, 8'h55};
    send_frame(0); run_check("reenable");

    clear_obs(); frame = '{8'h57};
    send_frame(0);
`ifdef HBIF_TIMEOUT_EN
    run_check("timeout");
`else
    repeat (100) @(negedge clk);
    chk("no_timeout_tx", 32'(tx_q.size()), 32'd0);
    chk("no_timeout_busy", 32'(busy), 32'd1);
    chk("no_timeout_txn", 32'(txn_n), 32'd0);
    frame = '{8'h57, 8'h5A, 8'h01, 8'h02};
    send_frame(1); run_check("late_frame");
`endif
    clear_obs(); frame = '{8'h52, 8'h7C}; rdata_val = 16'h1234;
    send_frame(0); run_check("after_partial");

    clear_obs(); resp_en = 1'b0;
    frame = '{8'h57, 8'h33, 8'h11, 8'h22};
    send_frame(0);
    k = 0;
    while (bif.reg_req_o !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    chk("bus_req_seen", 32'(bif.reg_req_o), 32'd1);
    repeat (3) @(negedge clk);
    chk("bus_req_held", 32'(bif.reg_req_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstbus_req", 32'(bif.reg_req_o), 32'd0);
    chk("rstbus_we", 32'(bif.reg_we_o), 32'd0);
    chk("rstbus_addr", 32'(bif.reg_addr_o), 32'd0);
    chk("rstbus_tx", 32'(tx), 32'd1);
    chk("rstbus_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1; resp_en = 1'b1;

    clear_obs();
    send_byte(8'h41, 1'b1);
    k = 0;
    while (tx !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    chk("tx_started", 32'(tx), 32'd0);
    #1 rst_n = 1'b0;
    #1 chk("rsttx_line", 32'(tx), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (60) @(negedge clk);

    clear_obs(); frame = '{8'h52, 8'hA5}; rdata_val = 16'h9E01;
    send_frame(0); run_check("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
